stack_sequencer: RTL
====================

Name: stack_sequencer

Overview:
- Sequences multi-register stack transfers described by the decoder's 16-bit push/pop bitmasks (bit order AW=0 … DS0=12, PC=13, MODRM=14, IMM=15).
- Issues one word bus transfer per set bit, reads and writes the register file, and tracks SP.
- Sits between the execution unit (start/done), the register file and the bus interface unit.
- Used for PUSH/POP, PUSH R/POP R, CALL/RET/RETI and interrupt entry.

Parameters:
- none

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  begin sequence; sampled only in IDLE
- push_mask  in  16  registers to push
- pop_mask  in  16  registers to pop
- sp_in  in  16  current SP, sampled with start
- reg_sel  out  4  bit index of the register being accessed
- reg_rdata  in  16  register file read data for reg_sel (combinational, same cycle)
- reg_we  out  1  register file write strobe
- reg_wdata  out  16  popped value
- mem_req  out  1  bus request; held until mem_ack
- mem_wr  out  1  1 = write (push), 0 = read (pop)
- mem_addr  out  16  SS-relative offset
- mem_wdata  out  16  push data
- mem_ack  in  1  transfer complete; mem_rdata valid in the same cycle
- mem_rdata  in  16  pop data
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- sp_we  out  1  one-cycle pulse, coincident with done
- sp_out  out  16  final SP, valid while sp_we = 1

Behaviour:
- Reset: state IDLE; all outputs 0. Working masks, sp_work and sp_orig are cleared.
- Reset mid-operation aborts immediately: mem_req drops and no writeback occurs.
- States: IDLE, POP_REQ, POP_WB, PUSH_SEL, PUSH_REQ, FIN.
- IDLE:
  - On start, latch both masks, sp_work = sp_orig = sp_in, and set busy = 1.
  - Next state: POP_REQ if pop_mask ≠ 0, else PUSH_SEL if push_mask ≠ 0, else FIN.
  - start while busy is ignored.
- Pops always complete before pushes.
- Pop order is highest set bit first. Push order is lowest set bit first. This gives the V30 RETI order (PC, PS, PSW) and the PUSH R order (AW … IY).
- POP_REQ:
  - reg_sel = highest remaining pop bit; mem_req = 1, mem_wr = 0, mem_addr = sp_work.
  - On mem_ack: capture mem_rdata into reg_wdata, clear the bit, sp_work += 2, go to POP_WB.
- POP_WB:
  - reg_we = 1 for exactly one cycle.
  - Exception: bit 4 (SP) is discarded, reg_we = 0, but SP still advances.
  - Next state: POP_REQ if pop bits remain, else PUSH_SEL if push bits remain, else FIN.
- PUSH_SEL:
  - reg_sel = lowest remaining push bit.
  - Capture reg_rdata into mem_wdata. Exception: bit 4 captures sp_orig, because pushed SP is the pre-sequence value.
  - Go to PUSH_REQ.
- PUSH_REQ:
  - mem_req = 1, mem_wr = 1, mem_addr = sp_work − 2.
  - mem_addr, mem_wdata, mem_wr and reg_sel are stable until ack.
  - On mem_ack: clear the bit, sp_work −= 2; go to PUSH_SEL if bits remain, else FIN.
- FIN: done = 1, sp_we = 1, sp_out = sp_work, busy = 0 for one cycle, then IDLE. start is not accepted in FIN.
- Latency:
  - Pop word = (1 + ack wait) + 1 cycles.
  - Push word = 1 + (1 + ack wait) cycles.
  - Empty masks: done 2 cycles after start.
- mem_ack outside POP_REQ/PUSH_REQ is ignored.
- mem_req is never asserted in consecutive transfers without an intervening non-request cycle.
- SP arithmetic is modulo 2^16 (0x0000 − 2 = 0xFFFE; 0xFFFE + 2 = 0x0000).

Optional Feature:
- Macro: STACK_SEQ_ABORT_EN
- With the macro, input port abort (1 bit) is added:
  - In POP_REQ/PUSH_REQ, the current transfer completes (waits for mem_ack), then the block goes to FIN and remaining bits are discarded. A pending POP_WB still writes back.
  - In PUSH_SEL/POP_WB, it goes to FIN next cycle.
  - sp_out reflects completed transfers only.
  - abort is ignored in IDLE and FIN.
- Without the macro, the port is absent and sequences always run to completion.

Test Plan:
- PUSH R:
  - Stimulus: push_mask = 0x00FF, sp_in = 0x1000, register file AW..IY = 0x1111..0x8888, ack one cycle after request.
  - Required: writes in order 0x0FFE←0x1111, 0x0FFC←0x2222, …; SP slot (0x0FF6) = 0x1000; last write 0x0FF0←0x8888; sp_out = 0x0FF0; done once.
- RETI:
  - Stimulus: pop_mask = 0x2600, sp_in = 0x0FFA, memory 0x0FFA = 0x0123, 0x0FFC = 0xF000, 0x0FFE = 0x0202.
  - Required: reg writes PC = 0x0123, PS = 0xF000, PSW = 0x0202 in that order; sp_out = 0x1000.
- POP R:
  - Stimulus: pop_mask = 0x00FF, sp_in = 0x0FF0.
  - Required: 8 reads; 7 reg_we pulses with no write for bit 4; sp_out = 0x1000.
- Wrap plus wait states:
  - Stimulus: push_mask = 0x2400, sp_in = 0x0002, mem_ack delayed 3 cycles.
  - Required: addresses 0x0000 then 0xFFFE; request signals stable through the wait; sp_out = 0xFFFE.
- Empty and busy start:
  - Stimulus: masks = 0, start.
  - Required: done and sp_we 2 cycles later, sp_out = sp_in.
  - Stimulus: start pulsed mid-sequence.
  - Required: ignored.
- Reset and abort:
  - Stimulus: reset_n low during PUSH_REQ.
  - Required: mem_req = 0 immediately, IDLE after release.
  - Stimulus (with STACK_SEQ_ABORT_EN): abort during the 2nd of 8 pushes.
  - Required: 2 writes total, sp_out = sp_in − 4.

Source files
------------

// File: rtl/stack_sequencer.sv
// Stack transfer sequencer: walks the push/pop bitmasks, one bus word per set bit, and tracks SP.
// Optional STACK_SEQ_ABORT_EN adds an abort input that cuts a sequence short after the current word.
module stack_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] push_mask,
    input  logic [15:0] pop_mask,
    input  logic [15:0] sp_in,
    output logic [3:0]  reg_sel,
    input  logic [15:0] reg_rdata,
    output logic        reg_we,
    output logic [15:0] reg_wdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic        sp_we,
    output logic [15:0] sp_out
`ifdef STACK_SEQ_ABORT_EN
    ,
    input  logic        abort
`endif
);

    // state     | meaning
    // IDLE      | waiting for start
    // POP_REQ   | bus read of highest remaining pop bit
    // POP_WB    | register file write of the popped word
    // PUSH_SEL  | capture data for lowest remaining push bit
    // PUSH_REQ  | bus write of the captured word
    // FIN       | done / SP writeback pulse
    typedef enum logic [2:0] {
        S_IDLE, S_POP_REQ, S_POP_WB, S_PUSH_SEL, S_PUSH_REQ, S_FIN
    } state_t;

    localparam logic [3:0] SP_BIT = 4'd4;

    state_t      state_q, state_d;
    logic [15:0] pop_q, pop_d;
    logic [15:0] push_q, push_d;
    logic [15:0] sp_work_q, sp_work_d;
    logic [15:0] sp_orig_q, sp_orig_d;
    logic [3:0]  sel_q, sel_d;
    logic [15:0] rdata_q, rdata_d;
    logic [15:0] wdata_q, wdata_d;
    logic        abort_pend_q, abort_pend_d;
    logic        abort_w;
    logic [3:0]  pop_hi, push_lo;

`ifdef STACK_SEQ_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    function automatic logic [3:0] hi_bit(input logic [15:0] m);
        hi_bit = '0;
        for (int i = 0; i < 16; i++)
            if (m[i]) hi_bit = 4'(i);
    endfunction

    function automatic logic [3:0] lo_bit(input logic [15:0] m);
        lo_bit = '0;
        for (int i = 15; i >= 0; i--)
            if (m[i]) lo_bit = 4'(i);
    endfunction

    assign pop_hi    = hi_bit(pop_q);
    assign push_lo   = lo_bit(push_q);
    assign reg_wdata = rdata_q;
    assign mem_wdata = wdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            pop_q        <= '0;
            push_q       <= '0;
            sp_work_q    <= '0;
            sp_orig_q    <= '0;
            sel_q        <= '0;
            rdata_q      <= '0;
            wdata_q      <= '0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pop_q        <= pop_d;
            push_q       <= push_d;
            sp_work_q    <= sp_work_d;
            sp_orig_q    <= sp_orig_d;
            sel_q        <= sel_d;
            rdata_q      <= rdata_d;
            wdata_q      <= wdata_d;
            abort_pend_q <= abort_pend_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pop_d        = pop_q;
        push_d       = push_q;
        sp_work_d    = sp_work_q;
        sp_orig_d    = sp_orig_q;
        sel_d        = sel_q;
        rdata_d      = rdata_q;
        wdata_d      = wdata_q;
        abort_pend_d = abort_pend_q;
        reg_sel      = '0;
        reg_we       = 1'b0;
        mem_req      = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        busy         = 1'b1;
        done         = 1'b0;
        sp_we        = 1'b0;
        sp_out       = '0;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    pop_d        = pop_mask;
                    push_d       = push_mask;
                    sp_work_d    = sp_in;
                    sp_orig_d    = sp_in;
                    abort_pend_d = 1'b0;
                    if (pop_mask != '0)       state_d = S_POP_REQ;
                    else if (push_mask != '0) state_d = S_PUSH_SEL;
                    else                      state_d = S_FIN;
                end
            end
            S_POP_REQ: begin
                reg_sel  = pop_hi;
                mem_req  = 1'b1;
                mem_addr = sp_work_q;
                if (abort_w) abort_pend_d = 1'b1;
                if (mem_ack) begin
                    rdata_d        = mem_rdata;
                    sel_d          = pop_hi;
                    pop_d[pop_hi]  = 1'b0;
                    sp_work_d      = sp_work_q + 16'd2;
                    state_d        = S_POP_WB;
                end
            end
            S_POP_WB: begin
                reg_sel = sel_q;
                // A popped SP word is dropped; SP is owned by sp_we/sp_out.
                reg_we  = (sel_q != SP_BIT);
                if (abort_w || abort_pend_q) state_d = S_FIN;
                else if (pop_q != '0)        state_d = S_POP_REQ;
                else if (push_q != '0)       state_d = S_PUSH_SEL;
                else                         state_d = S_FIN;
            end
            S_PUSH_SEL: begin
                reg_sel = push_lo;
                if (abort_w) begin
                    state_d = S_FIN;
                end else begin
                    sel_d   = push_lo;
                    wdata_d = (push_lo == SP_BIT) ? sp_orig_q : reg_rdata;
                    state_d = S_PUSH_REQ;
                end
            end
            S_PUSH_REQ: begin
                reg_sel  = sel_q;
                mem_req  = 1'b1;
                mem_wr   = 1'b1;
                mem_addr = sp_work_q - 16'd2;
                if (abort_w) abort_pend_d = 1'b1;
                if (mem_ack) begin
                    push_d[sel_q] = 1'b0;
                    sp_work_d     = sp_work_q - 16'd2;
                    if (abort_w || abort_pend_q)                 state_d = S_FIN;
                    else if ((push_q & ~(16'd1 << sel_q)) != '0) state_d = S_PUSH_SEL;
                    else                                         state_d = S_FIN;
                end
            end
            S_FIN: begin
                busy         = 1'b0;
                done         = 1'b1;
                sp_we        = 1'b1;
                sp_out       = sp_work_q;
                abort_pend_d = 1'b0;
                state_d      = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
